// File: rtl/fp_sqrt_iter_if.sv
// Handshake and data bundle for the iterative single-precision square root unit.
// The requester drives start/a/rm; the unit returns busy/done/result and flags.
interface fp_sqrt_iter_if;
   logic        start;
   logic [31:0] a;
   logic [2:0]  rm;
   logic        busy;
   logic        done;
   logic [31:0] result;
   logic        nv;
   logic        nx;

   modport master (
      output start, a, rm,
      input  busy, done, result, nv, nx
   );

   modport slave (
      input  start, a, rm,
      output busy, done, result, nv, nx
   );
endinterface

// File: rtl/fp_sqrt_iter.sv
// Iterative IEEE-754 single-precision square root: one root bit per cycle using a
// restoring digit recurrence, followed by a single rounding step.
module fp_sqrt_iter (
   input logic           clk,
   input logic           reset,
   fp_sqrt_iter_if.slave bus
);
   typedef enum logic [2:0] {StIdle, StPrep, StIter, StRound, StDone} state_e;

   state_e      state_q, state_d;
   logic [31:0] a_q;
   logic [2:0]  rm_q;
   logic [49:0] rad_q;
   logic [27:0] rem_q;
   logic [24:0] root_q;
   logic [4:0]  cnt_q;
   logic [7:0]  exp_q;
   logic [31:0] res_q;
   logic        nv_q, nx_q;

   logic        sgn;
   logic [7:0]  ex;
   logic [22:0] fr;
   logic        is_nan, is_inf, is_zero, special, spec_nv;
   logic [31:0] spec_res;
   logic [23:0] mant24, norm;
   logic [4:0]  lz;
   logic signed [9:0] e_unb, e_half;
   logic [7:0]  prep_exp;
   logic [24:0] rad25;
   logic [27:0] rem_sh, trial, rem_nx;
   logic        ge;
   logic [24:0] root_nx;
   logic        guard, sticky, inc;
   logic [31:0] round_res;

   assign sgn = a_q[31];
   assign ex  = a_q[30:23];
   assign fr  = a_q[22:0];

   always_comb begin
      is_nan   = (ex == 8'hFF) && (fr != 23'd0);
      is_inf   = (ex == 8'hFF) && (fr == 23'd0);
      is_zero  = (ex == 8'h00) && (fr == 23'd0);
      special  = is_nan | is_inf | is_zero | sgn;
      spec_nv  = 1'b0;
      spec_res = 32'h7FC0_0000;
      if (is_nan) begin
         spec_nv = ~fr[22];
      end else if (is_zero) begin
         spec_res = {sgn, 31'd0};
      end else if (sgn) begin
         spec_nv = 1'b1;
      end else if (is_inf) begin
         spec_res = 32'h7F80_0000;
      end
   end

   // Normalize subnormals; odd exponents fold one bit into the radicand.
   always_comb begin
      mant24 = {(ex != 8'd0), fr};
      lz     = 5'd24;
      for (int i = 0; i < 24; i++) begin
         if (mant24[i]) lz = 5'(23 - i);
      end
      norm = mant24 << lz;
      if (ex == 8'd0) e_unb = -10'sd126 - $signed({5'd0, lz});
      else            e_unb = $signed({2'd0, ex}) - 10'sd127 - $signed({5'd0, lz});
      e_half   = e_unb >>> 1;
      prep_exp = 8'(e_half + 10'sd127);
      rad25    = e_unb[0] ? {norm, 1'b0} : {1'b0, norm};
   end

   always_comb begin
      rem_sh  = (rem_q << 2) | {26'd0, rad_q[49:48]};
      trial   = {1'b0, root_q, 2'b01};
      ge      = (rem_sh >= trial);
      rem_nx  = ge ? (rem_sh - trial) : rem_sh;
      root_nx = {root_q[23:0], ge};
   end

   // Result is positive here, so RDN truncates and RUP rounds away on any residue.
   always_comb begin
      guard = root_q[0];
      sticky = |rem_q;
      case (rm_q)
         3'b001, 3'b010: inc = 1'b0;
         3'b011:         inc = guard | sticky;
         3'b100:         inc = guard;
         default:        inc = guard & (sticky | root_q[1]);
      endcase
      // A mantissa carry ripples into the exponent field.
      round_res = {1'b0, exp_q, root_q[23:1]} + {31'd0, inc};
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         StIdle:  if (bus.start) state_d = StPrep;
         StPrep:  state_d = special ? StDone : StIter;
         StIter:  if (cnt_q == 5'd24) state_d = StRound;
         StRound: state_d = StDone;
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) state_q <= StIdle;
      else       state_q <= state_d;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         a_q    <= 32'd0;
         rm_q   <= 3'd0;
         rad_q  <= 50'd0;
         rem_q  <= 28'd0;
         root_q <= 25'd0;
         cnt_q  <= 5'd0;
         exp_q  <= 8'd0;
         res_q  <= 32'd0;
         nv_q   <= 1'b0;
         nx_q   <= 1'b0;
      end else begin
         case (state_q)
            StIdle: begin
               if (bus.start) begin
                  a_q  <= bus.a;
                  rm_q <= bus.rm;
               end
            end
            StPrep: begin
               rad_q  <= {rad25, 25'd0};
               rem_q  <= 28'd0;
               root_q <= 25'd0;
               cnt_q  <= 5'd0;
               exp_q  <= prep_exp;
               if (special) begin
                  res_q <= spec_res;
                  nv_q  <= spec_nv;
                  nx_q  <= 1'b0;
               end
            end
            StIter: begin
               rad_q  <= rad_q << 2;
               rem_q  <= rem_nx;
               root_q <= root_nx;
               cnt_q  <= cnt_q + 5'd1;
            end
            StRound: begin
               res_q <= round_res;
               nv_q  <= 1'b0;
               nx_q  <= guard | sticky;
            end
            default: ;
         endcase
      end
   end

   assign bus.busy   = (state_q != StIdle);
   assign bus.done   = (state_q == StDone);
   assign bus.result = res_q;
   assign bus.nv     = nv_q;
   assign bus.nx     = nx_q;
endmodule

// File: doc/fp_sqrt_iter.md
FP_SQRT_ITER -- requirements
Module: fp_sqrt_iter

Interface
REQ-001 SHALL have one clock and a synchronous active-high reset.
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request; sampled only in IDLE.
REQ-005 a  input  32  IEEE-754 single operand; captured with start.
REQ-006 rm  input  3  rounding mode, captured with start: 000 RNE, 001 RTZ, 010 RDN, 011 RUP, 100 RMM; 101-111 treated as RNE.
REQ-007 busy  output  1  high from the cycle after start is accepted until done is high, inclusive.
REQ-008 done  output  1  one-cycle pulse; result and flags valid in that cycle.
REQ-009 result  output  32  square root of a; held until the next accepted start.
REQ-010 nv  output  1  invalid-operation flag, valid with done.
REQ-011 nx  output  1  inexact flag, valid with done.

Function
REQ-012 SHALL implement the FSM states IDLE, PREP, ITER, ROUND, DONE.
REQ-013 IDLE->PREP when start=1; start in any other state SHALL be ignored, with no queuing.
REQ-014 PREP: unpack a, classify it, and normalize a subnormal mantissa with a leading-zero shift and exponent adjust.
- Special input goes to DONE; otherwise goes to ITER.
REQ-015 Exponent rule: unbiased e = E-127, or the normalized value for subnormals.
- If e is odd: mantissa <<= 1 and e -= 1.
- Result exponent = e/2 + 127 (arithmetic shift).
REQ-016 ITER: restoring digit-by-digit square root, one root bit per cycle, exactly 25 cycles (24 significand bits + guard).
- Sticky = remainder != 0 at the end.
REQ-017 ROUND: round the 24-bit root using guard and sticky per rm. Result is always positive, so:
- RDN behaves as RTZ.
- RUP increments when guard|sticky.
- RMM increments when guard.
- RNE increments when guard & (sticky | lsb).
REQ-018 A rounding carry out of the significand SHALL give mantissa 0 with exponent+1.
REQ-019 nx SHALL be guard|sticky for normal operands and 0 for special operands.
REQ-020 Latency: with start accepted at edge N, done SHALL be high in cycle N+28 for normal/subnormal operands and N+2 for special operands.
- DONE returns to IDLE the next cycle.
REQ-021 Special cases, with nx=0:
- qNaN in -> 0x7FC00000, nv=0.
- sNaN in -> 0x7FC00000, nv=1.
- Negative nonzero, including -inf -> 0x7FC00000, nv=1.
- +0 -> 0x00000000; -0 -> 0x80000000.
- +inf -> 0x7F800000.
REQ-022 Result SHALL never be subnormal, overflow, or carry sign 1, except the -0 case.
REQ-023 A new start MAY be accepted in the cycle after DONE (IDLE); back-to-back operations SHALL NOT corrupt a held result before done.

Reset
REQ-024 reset=1 SHALL force, at the next edge: state IDLE, busy=0, done=0, result=0, nv=0, nx=0.
REQ-025 Reset in any state, including mid-ITER, SHALL abort the operation with no done pulse; reset SHALL have priority over start.

Verification
REQ-026 a=0x40800000 (4.0), rm=RNE -> result 0x40000000, nx=0, nv=0, done exactly 28 cycles after start.
REQ-027 a=0x40000000 (2.0):
- RNE -> 0x3FB504F3, nx=1.
- RTZ -> 0x3FB504F3.
- RUP -> 0x3FB504F4.
REQ-028 a=0x00000001 (smallest subnormal), RNE -> 0x1A3504F3, nx=1.
REQ-029 Specials, each with done at +2:
- a=0xBF800000 -> 0x7FC00000, nv=1.
- a=0x80000000 -> 0x80000000.
- a=0x7F800000 -> 0x7F800000.
- a=0x7F800001 -> 0x7FC00000, nv=1.
REQ-030 Start with a=0x40800000, assert reset 10 cycles later:
- busy=0 next cycle, no done pulse.
- A following start with a=0x41100000 (9.0) -> 0x40400000 at +28.
REQ-031 Start pulsed again while busy -> ignored.
- Single done with the first operand's result.
- busy deasserts in the cycle after done.
